keyboard_decoder: RTL and testbench

Receives PS/2 set-2 scancodes from the keyboard, deserializes and checks each frame, and filters out release and extended sequences. It maps the game keys (W, A, S, D, Space, Z) to 3-bit operation codes. A 2-entry FIFO buffers those codes, and the block hands them to the game-logic stage over a four-phase ready/read_fin handshake. It sits directly upstream of the game player logic and directly downstream of the board's PS/2 pins.

---
 rtl/generals_pkg.sv | 66 ++++++
 rtl/ps2_rx.sv | 150 +++++++++++++++
 rtl/keyboard_decoder.sv | 157 +++++++++++++++
 tb/tb_keyboard_decoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/generals_pkg.sv
// -----------------------------------------------------------------------------
// generals_pkg
//   Definitions shared by the keyboard front end and the game-player logic.
//   - operation_t : 3-bit operation code handed from the keyboard to the game.
//   - Set-2 make codes of the game keys plus the BREAK (0xF0) and EXTEND (0xE0)
//     prefixes.
//   - State encodings of the PS/2 frame receiver and the output handshake FSM.
//   - map_scancode : translates a make code into an operation (hit=0 when the
//     byte is not a game key).
// -----------------------------------------------------------------------------
package generals_pkg;

    typedef enum logic [2:0] {
        OP_W     = 3'b000,
        OP_A     = 3'b001,
        OP_S     = 3'b010,
        OP_D     = 3'b011,
        OP_SPACE = 3'b100,
        OP_Z     = 3'b101,
        OP_NONE  = 3'b110
    } operation_t;

    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_VALID,
        OUT_WAIT
    } out_state_t;

    typedef struct packed {
        logic       hit;
        operation_t op;
    } key_map_t;

    function automatic key_map_t map_scancode(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.op  = OP_NONE;
        case (code)
            SC_W:     m.op = OP_W;
            SC_A:     m.op = OP_A;
            SC_S:     m.op = OP_S;
            SC_D:     m.op = OP_D;
            SC_SPACE: m.op = OP_SPACE;
            SC_Z:     m.op = OP_Z;
            default:  m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
//   PS/2 device-to-host frame receiver.
//   Both pins are brought into the clock domain with two flops each; the
//   PS/2 clock is then cleaned by a 3-sample majority filter and its filtered
//   1->0 transitions drive an 11-bit frame FSM (start, 8 data LSB first, odd
//   parity, stop). A partial frame is abandoned when no falling edge arrives
//   for TIMEOUT_CYCLES clocks.
//
// Ports
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   ps2_clock   in   raw PS/2 clock pin
//   ps2_data    in   raw PS/2 data pin
//   rx_byte     out  last received byte, valid while byte_valid is high
//   byte_valid  out  one-cycle strobe for a correctly framed byte
//   frame_error out  one-cycle pulse on start/parity/stop/timeout failure
// -----------------------------------------------------------------------------
module ps2_rx
    import generals_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic            ps2_clock_p0, ps2_clock_p1;
    logic            ps2_data_p0, ps2_data_p1;
    logic [1:0]      clk_hist_p2;
    logic            clk_filt_p3, clk_filt_p4;
    logic            fall_edge;

    rx_state_t       state;
    logic [2:0]      bit_cnt;
    logic            parity_ok;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      shift_reg;

    // Stage p0/p1: two-flop synchronizers. Reset to the idle-high bus level so
    // leaving reset never fakes a falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps2_clock_p0 <= 1'b1;
            ps2_clock_p1 <= 1'b1;
            ps2_data_p0  <= 1'b1;
            ps2_data_p1  <= 1'b1;
        end else begin
            ps2_clock_p0 <= ps2_clock;
            ps2_clock_p1 <= ps2_clock_p0;
            ps2_data_p0  <= ps2_data;
            ps2_data_p1  <= ps2_data_p0;
        end
    end

    // Stage p2..p4: majority of the newest synchronized sample and the two
    // before it; the filtered level is registered, then delayed once more so
    // the edge detect compares two registered values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_hist_p2 <= 2'b11;
            clk_filt_p3 <= 1'b1;
            clk_filt_p4 <= 1'b1;
        end else begin
            clk_hist_p2 <= {clk_hist_p2[0], ps2_clock_p1};
            clk_filt_p3 <= maj3(ps2_clock_p1, clk_hist_p2[0], clk_hist_p2[1]);
            clk_filt_p4 <= clk_filt_p3;
        end
    end

    assign fall_edge = clk_filt_p4 & ~clk_filt_p3;

    // Frame FSM and inactivity counter. A falling edge always wins over the
    // timeout because it also restarts the counter in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RX_IDLE;
            bit_cnt     <= '0;
            parity_ok   <= 1'b0;
            to_cnt      <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;

            if (fall_edge) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (fall_edge) begin
                case (state)
                    RX_IDLE: begin
                        // A start bit sampled high is line noise: stay idle.
                        if (!ps2_data_p1) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_ok <= ^{shift_reg, ps2_data_p1};
                        state     <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (ps2_data_p1 && parity_ok) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end else if (state != RX_IDLE && to_cnt == TO_MAX) begin
                state       <= RX_IDLE;
                frame_error <= 1'b1;
            end
        end
    end

    // Data shift register, LSB arrives first so bits enter from the top.
    always_ff @(posedge clock) begin
        if (fall_edge && state == RX_DATA) begin
            shift_reg <= {ps2_data_p1, shift_reg[7:1]};
        end
    end

    assign rx_byte = shift_reg;

endmodule

// File: rtl/keyboard_decoder.sv
// -----------------------------------------------------------------------------
// keyboard_decoder
//   PS/2 keyboard front end for the game. Received bytes are filtered for
//   release (0xF0 xx) and extended (0xE0 xx) sequences, game keys are mapped
//   to operation codes, buffered in a small FIFO and presented to the game
//   logic over a four-phase ready/read_fin handshake.
//
// Ports
//   clock              in   system clock
//   reset              in   asynchronous active-high reset
//   ps2_clock          in   raw PS/2 clock pin
//   ps2_data           in   raw PS/2 data pin
//   keyboard_read_fin  in   consumer acknowledge for the presented code
//   keyboard_ready     out  a code is presented on keyboard_data
//   keyboard_data      out  operation code, NONE (110) while not ready
//   frame_error        out  one-cycle pulse on a bad or abandoned frame
//   overflow           out  one-cycle pulse when a code is dropped (FIFO full)
// -----------------------------------------------------------------------------
module keyboard_decoder
    import generals_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       keyboard_read_fin,
    output logic       keyboard_ready,
    output logic [2:0] keyboard_data,
    output logic       frame_error,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [7:0]       rx_byte;
    logic             byte_valid;

    logic             brk, ext;
    key_map_t         key;
    logic             mapped, fifo_full, push, pop;

    operation_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    out_state_t       out_state;
    operation_t       data_q;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_error(frame_error)
    );

    // Decode: a byte counts only when neither prefix flag is pending, i.e.
    // the previous byte was not 0xF0 or 0xE0.
    always_comb begin
        key       = map_scancode(rx_byte);
        mapped    = byte_valid & key.hit & ~brk & ~ext;
        fifo_full = (fifo_count == CNT_FULL);
        push      = mapped & ~fifo_full;
        pop       = (out_state == OUT_VALID) & keyboard_read_fin;
    end

    // Decode/push stage: prefix flags, FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk        <= 1'b0;
            ext        <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            overflow <= mapped & fifo_full;

            if (byte_valid) begin
                if (rx_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == SC_EXTEND) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; full FIFO blocks the write so entries are never overwritten.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= key.op;
        end
    end

    // Present stage: four-phase handshake. The head stays in the FIFO until
    // the consumer acknowledges it, so a held-off consumer counts against
    // the buffer capacity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_state      <= OUT_IDLE;
            keyboard_ready <= 1'b0;
            data_q         <= OP_NONE;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (fifo_count != '0 && !keyboard_read_fin) begin
                        data_q         <= fifo_mem[rd_ptr];
                        keyboard_ready <= 1'b1;
                        out_state      <= OUT_VALID;
                    end
                end
                OUT_VALID: begin
                    if (keyboard_read_fin) begin
                        data_q         <= OP_NONE;
                        keyboard_ready <= 1'b0;
                        out_state      <= OUT_WAIT;
                    end
                end
                OUT_WAIT: begin
                    if (!keyboard_read_fin) begin
                        out_state <= OUT_IDLE;
                    end
                end
                default: out_state <= OUT_IDLE;
            endcase
        end
    end

    assign keyboard_data = data_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// -----------------------------------------------------------------------------
// tb_keyboard_decoder
//   Drives PS/2 frames into keyboard_decoder and compares every presented
//   operation code against a scoreboard fed by a key-level reference model.
//   A consumer process acknowledges codes one cycle after ready and holds
//   read_fin for two cycles.
// -----------------------------------------------------------------------------
module tb_keyboard_decoder;

    localparam int TO   = 200;
    localparam int HALF = 10;
    localparam int NONE = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       keyboard_read_fin = 1'b0;
    logic       keyboard_ready;
    logic [2:0] keyboard_data;
    logic       frame_error;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    int exp_q[$];
    int occ = 0;
    bit prefix_seen = 1'b0;
    int exp_ferr = 0, exp_ovf = 0;
    int seen_ferr = 0, seen_ovf = 0;
    bit cons_en = 1'b0;

    keyboard_decoder #(
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ps2_clock        (ps2_clock),
        .ps2_data         (ps2_data),
        .keyboard_read_fin(keyboard_read_fin),
        .keyboard_ready   (keyboard_ready),
        .keyboard_data    (keyboard_data),
        .frame_error      (frame_error),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int key_code(input int b);
        case (b)
            'h1D:    return 0;
            'h1C:    return 1;
            'h1B:    return 2;
            'h23:    return 3;
            'h29:    return 4;
            'h1A:    return 5;
            default: return -1;
        endcase
    endfunction

    // Reference model: a key is forwarded when the previous good byte was
    // not a prefix; at most two codes may be waiting for an acknowledge.
    task automatic model_byte(input int b, input bit bad);
        if (bad) begin
            exp_ferr++;
            return;
        end
        if (b == 'hF0 || b == 'hE0) begin
            prefix_seen = 1'b1;
        end else begin
            if (!prefix_seen && key_code(b) >= 0) begin
                if (occ >= 2) begin
                    exp_ovf++;
                end else begin
                    exp_q.push_back(key_code(b));
                    occ++;
                end
            end
            prefix_seen = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input bit d, input bit chk_lat, input int exp_code);
        ps2_data = d;
        tick(HALF);
        ps2_clock = 1'b0;
        if (chk_lat) begin
            repeat (6) @(posedge clock);
            @(negedge clock);
            check("lat_ready_at_6", keyboard_ready, 0);
            @(posedge clock);
            @(negedge clock);
            check("lat_ready_at_7", keyboard_ready, 1);
            check("lat_data", keyboard_data, exp_code);
            tick(HALF - 7);
        end else begin
            tick(HALF);
        end
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input int b, input bit bad, input bit chk_lat);
        logic [7:0] v;
        bit par;
        v = b[7:0];
        par = ~^v;
        if (bad) par = ~par;
        ps2_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(v[i], 1'b0, 0);
        ps2_bit(par, 1'b0, 0);
        model_byte(b, bad);
        ps2_bit(1'b1, chk_lat, key_code(b));
        ps2_data = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || keyboard_ready) && n < 100) begin
            tick(1);
            n++;
        end
        check({name, "_all_delivered"}, exp_q.size(), 0);
    endtask

    // Monitor: compares each newly presented code with the scoreboard head.
    initial begin
        bit ready_prev;
        bit had_xfer;
        int low_run;
        int e;
        ready_prev = 1'b0;
        had_xfer   = 1'b0;
        low_run    = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ready_prev = 1'b0;
                had_xfer   = 1'b0;
                low_run    = 0;
            end else begin
                if (frame_error) seen_ferr++;
                if (overflow) seen_ovf++;
                if (keyboard_ready && !ready_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_xfer: got data %0d expected no transfer", keyboard_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_data", keyboard_data, e);
                    end
                    if (had_xfer) check("xfer_gap_ge2", int'(low_run >= 2), 1);
                    had_xfer = 1'b1;
                end
                if (!keyboard_ready && ready_prev) begin
                    occ--;
                    check("data_none_after_pop", keyboard_data, NONE);
                end
                low_run    = keyboard_ready ? 0 : low_run + 1;
                ready_prev = keyboard_ready;
            end
        end
    end

    // Consumer: registers read_fin one cycle after seeing ready, holds it two cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (cons_en && !reset && keyboard_ready && !keyboard_read_fin) begin
                @(posedge clock);
                #1 keyboard_read_fin = 1'b1;
                tick(2);
                keyboard_read_fin = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int choices[9];
        int b;
        bit bad;
        choices = '{'h1D, 'h1C, 'h1B, 'h23, 'h29, 'h1A, 'hF0, 'hE0, 'h12};

        reset = 1'b1;
        tick(3);
        check("rst_ready", keyboard_ready, 0);
        check("rst_data", keyboard_data, NONE);
        check("rst_ferr", frame_error, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick(5);
        cons_en = 1'b1;

        // Single W with exact latency.
        send_frame('h1D, 1'b0, 1'b1);
        drain("w_single");

        // Release and extended sequences.
        send_frame('h1C, 1'b0, 1'b0);
        send_frame('hF0, 1'b0, 1'b0);
        send_frame('h1C, 1'b0, 1'b0);
        send_frame('hE0, 1'b0, 1'b0);
        send_frame('h1D, 1'b0, 1'b0);
        drain("break_ext");

        // Bad parity then a good frame.
        send_frame('h23, 1'b1, 1'b0);
        check("parity_ferr", seen_ferr, exp_ferr);
        send_frame('h23, 1'b0, 1'b0);
        drain("after_parity");

        // Overflow with the consumer held off.
        cons_en = 1'b0;
        send_frame('h1D, 1'b0, 1'b0);
        send_frame('h1C, 1'b0, 1'b0);
        send_frame('h1B, 1'b0, 1'b0);
        check("ovf_count", seen_ovf, exp_ovf);
        check("ovf_expected_one", exp_ovf, 1);
        check("hold_ready", keyboard_ready, 1);
        check("hold_data", keyboard_data, 0);
        cons_en = 1'b1;
        drain("ovf_release");

        // Stalled partial frame, then a good SPACE.
        ps2_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0, 0);
        tick(TO + 10);
        exp_ferr++;
        check("timeout_ferr", seen_ferr, exp_ferr);
        send_frame('h29, 1'b0, 1'b0);
        drain("after_timeout");

        // Reset with a code buffered and a frame in flight.
        cons_en = 1'b0;
        send_frame('h1D, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0, 0);
        ps2_bit(1'b1, 1'b0, 0);
        ps2_data = 1'b0;
        tick(HALF);
        ps2_clock = 1'b0;
        tick(2);
        reset = 1'b1;
        #2;
        check("midrst_ready", keyboard_ready, 0);
        check("midrst_data", keyboard_data, NONE);
        check("midrst_ferr", frame_error, 0);
        check("midrst_ovf", overflow, 0);
        ps2_clock = 1'b1;
        ps2_data = 1'b1;
        exp_q.delete();
        occ = 0;
        prefix_seen = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(5);
        cons_en = 1'b1;
        send_frame('h1A, 1'b0, 1'b0);
        drain("after_reset");

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            b = choices[$urandom_range(0, 8)];
            if (b == 'h12) b = int'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            send_frame(b, bad, 1'b0);
        end
        drain("random");
        check("final_ferr", seen_ferr, exp_ferr);
        check("final_ovf", seen_ovf, exp_ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
